// File: rtl/fetch_unit_pkg.sv
// Core-wide shared definitions: default widths, fetch state encoding,
// the opcode constants used by the decoder, and a small alignment helper.
package fetch_unit_pkg;

    localparam int          XLEN_D     = 32;
    localparam logic [31:0] RESET_PC_D = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Major opcodes (inst[6:0]) shared with the decoder.
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Word fetches only: any nonzero low address bits is a fault.
    function automatic logic is_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Ports: clk/rst (async high), i_push/i_data write side, i_pop read side,
// i_flush empties the queue, o_data = head entry, o_count/o_empty/o_full.
// Depth must be a power of two so pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];

    // A pop frees a slot in the same cycle, so push+pop on a full queue is legal.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word requests to instruction
// memory, buffers returned words and hands {inst, inst_pc} to decode.
// Ports: clk/rst (async high); imem_req_* request channel (valid/ready);
// imem_resp_* in-order response channel (never back-pressured);
// redirect_* from execute; inst_* to decode (valid/ready); fault (sticky).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_D,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_D),
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault
);

    localparam int CW = $clog2(QDEPTH+1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_resp_pc;
    logic [CW-1:0]     r_out;     // requests accepted, response not yet seen
    logic [CW-1:0]     r_drop;    // responses still to discard after a redirect

    logic              w_in_fetch;
    logic              w_bad_tgt;
    logic              w_redir;
    logic [CW:0]       w_inflight;
    logic              w_credit;
    logic              w_acc;
    logic              w_resp;
    logic              w_keep;
    logic              w_pop;
    logic [2*XLEN-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;

    assign w_in_fetch = (r_state == ST_FETCH);
    assign w_bad_tgt  = is_misaligned(redirect_pc[1:0]);
    // Redirects are only honoured in FETCH; a misaligned one only changes state.
    assign w_redir    = w_in_fetch && redirect_valid && !w_bad_tgt;

    // Credit: outstanding requests plus queued words never exceed the FIFO depth,
    // which is what lets responses be pushed without back-pressure.
    assign w_inflight = {1'b0, r_out} + {1'b0, w_count};
    assign w_credit   = !w_full && (w_inflight < (CW+1)'(QDEPTH));

    assign imem_req_valid = w_in_fetch && w_credit && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_acc          = imem_req_valid && imem_req_ready;

    // Responses during BOOT (or FAULT) are ignored outright.
    assign w_resp = w_in_fetch && imem_resp_valid;
    assign w_keep = w_resp && !redirect_valid && (r_drop == '0);

    assign inst_valid = w_in_fetch && !w_empty;
    assign w_pop      = inst_valid && inst_ready;
    assign inst       = inst_valid ? w_head[2*XLEN-1:XLEN] : '0;
    assign inst_pc    = inst_valid ? w_head[XLEN-1:0]      : '0;
    assign fault      = (r_state == ST_FAULT);

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_keep),
        .i_data  ({imem_resp_data, r_resp_pc}),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: if (redirect_valid && w_bad_tgt) w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_FAULT;   // only reset leaves FAULT
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
        end else if (w_redir) begin
            // No request can be accepted in a redirect cycle, and a response
            // arriving now is discarded here, so it is not counted into drop.
            r_fetch_pc <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_out      <= r_out - CW'(w_resp);
            r_drop     <= r_out - CW'(w_resp);
        end else if (w_in_fetch && !redirect_valid) begin
            if (w_acc)  r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_keep) r_resp_pc  <= r_resp_pc + XLEN'(4);
            if (w_resp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            r_out <= r_out + CW'(w_acc) - CW'(w_resp);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-level reference model, an
// in-order memory responder with random latency, directed scenarios with
// hand-computed expectations, then randomized traffic with redirects.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid = 1'b0;
    logic [XLEN-1:0] imem_resp_data = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            fault;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // ---------------- reference model (queue level) ----------------
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    ent_t        m_q[$];
    int          m_state = 0;        // 0 boot, 1 fetch, 2 fault
    logic [31:0] m_fpc   = RESET_PC;
    logic [31:0] m_rpc   = RESET_PC;
    int          m_out   = 0;
    int          m_drop  = 0;

    pend_t       pend[$];
    int          cyc     = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic        s_acc   = 1'b0;
    logic [31:0] s_addr  = '0;
    logic [31:0] deliv[$];

    function automatic logic e_req();
        return (m_state == 1) && ((m_out + m_q.size()) < QDEPTH) && !redirect_valid;
    endfunction

    function automatic logic e_iv();
        return (m_state == 1) && (m_q.size() > 0);
    endfunction

    task automatic model_step();
        logic acc, pop;
        ent_t e;
        pend_t p;
        if (rst) begin
            m_q.delete(); m_state = 0; m_fpc = RESET_PC; m_rpc = RESET_PC;
            m_out = 0; m_drop = 0; pend.delete();
        end else begin
            acc = e_req() && imem_req_ready;
            pop = e_iv() && inst_ready;
            if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                if (redirect_valid && redirect_pc[1:0] != 2'b00) m_state = 2;
                else if (redirect_valid) begin
                    m_q.delete();
                    if (imem_resp_valid) m_out--;
                    m_drop = m_out;
                    m_fpc  = redirect_pc;
                    m_rpc  = redirect_pc;
                end else begin
                    if (pop) void'(m_q.pop_front());
                    if (acc) begin m_fpc += 4; m_out++; end
                    if (imem_resp_valid) begin
                        m_out--;
                        if (m_drop > 0) m_drop--;
                        else begin
                            e.inst = imem_resp_data; e.pc = m_rpc;
                            m_q.push_back(e);
                            m_rpc += 4;
                        end
                    end
                end
            end
            // memory side: retire the response just delivered, record new accept
            cyc++;
            if (imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
            if (s_acc) begin
                p.addr = s_addr;
                p.due  = cyc + int'($urandom_range(lat_max, lat_min));
                pend.push_back(p);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // In-order memory responder, never back-pressured.
    initial forever begin
        @(negedge clk);
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memfn(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        #1;
        s_acc  = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        chk("req_valid",  64'(imem_req_valid), 64'(e_req()));
        if (e_req()) chk("req_addr", 64'(imem_req_addr), 64'(m_fpc));
        chk("inst_valid", 64'(inst_valid), 64'(e_iv()));
        chk("fault",      64'(fault), 64'(m_state == 2));
        if (e_iv()) begin
            chk("inst",    64'(inst),    64'(m_q[0].inst));
            chk("inst_pc", 64'(inst_pc), 64'(m_q[0].pc));
        end else begin
            chk("inst_idle",    64'(inst),    64'(0));
            chk("inst_pc_idle", 64'(inst_pc), 64'(0));
        end
        if (inst_valid) chk("inst_vs_mem", 64'(inst), 64'(memfn(inst_pc)));
        if (inst_valid && inst_ready) deliv.push_back(inst_pc);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic        found;

        // reset values
        lat_min = 0; lat_max = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid",  64'(imem_req_valid), 64'(0));
        chk("rst_req_addr",   64'(imem_req_addr),  64'(RESET_PC));
        chk("rst_inst_valid", 64'(inst_valid),     64'(0));
        chk("rst_fault",      64'(fault),          64'(0));

        // zero-wait memory, decode always ready
        @(negedge clk);
        rst = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; deliv.delete();
        #1 chk("boot_no_req", 64'(imem_req_valid), 64'(0));
        @(negedge clk);
        #1 chk("first_req_valid", 64'(imem_req_valid), 64'(1));
        chk("first_req_addr", 64'(imem_req_addr), 64'(32'h0));
        @(negedge clk);
        #1 chk("resp_cycle_no_inst", 64'(inst_valid), 64'(0));
        @(negedge clk);
        #1 chk("first_inst_valid", 64'(inst_valid), 64'(1));
        chk("first_inst_pc", 64'(inst_pc), 64'(32'h0));
        chk("first_inst",    64'(inst),    64'(32'h5A5A_C3C3));
        repeat (20) @(negedge clk);
        chk("zw_count", 64'(deliv.size() >= 3), 64'(1));
        if (deliv.size() >= 3) begin
            chk("zw_pc0", 64'(deliv[0]), 64'(32'h0));
            chk("zw_pc1", 64'(deliv[1]), 64'(32'h4));
            chk("zw_pc2", 64'(deliv[2]), 64'(32'h8));
        end

        // stalled decode fills the queue and stops fetch
        do_reset();
        imem_req_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1 chk("stall_no_req", 64'(imem_req_valid), 64'(0));
        chk("stall_valid",   64'(inst_valid),    64'(1));
        chk("stall_head_pc", 64'(inst_pc),       64'(32'h0));
        chk("stall_addr",    64'(imem_req_addr), 64'(32'h8));
        deliv.delete();
        @(negedge clk);
        inst_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("drain_count", 64'(deliv.size() >= 3), 64'(1));
        if (deliv.size() >= 3) begin
            chk("drain_pc0", 64'(deliv[0]), 64'(32'h0));
            chk("drain_pc1", 64'(deliv[1]), 64'(32'h4));
            chk("drain_pc2", 64'(deliv[2]), 64'(32'h8));
        end

        // redirect with fetches in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #1;
            if (imem_req_valid && imem_req_addr == 32'hC) found = 1'b1;
        end
        chk("wait_req_C", 64'(found), 64'(1));
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1 chk("redir_no_req", 64'(imem_req_valid), 64'(0));
        @(negedge clk);
        redirect_valid = 1'b0; deliv.delete();
        #1 chk("redir_addr", 64'(imem_req_addr), 64'(32'h100));
        repeat (30) @(negedge clk);
        chk("redir_count", 64'(deliv.size() >= 2), 64'(1));
        if (deliv.size() >= 2) begin
            chk("redir_pc0", 64'(deliv[0]), 64'(32'h100));
            chk("redir_pc1", 64'(deliv[1]), 64'(32'h104));
        end

        // misaligned redirect -> sticky fault until reset
        lat_min = 0; lat_max = 2;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1 chk("fault_set", 64'(fault), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready     = 1'($urandom_range(0, 1));
        end
        #1 chk("fault_hold",     64'(fault),          64'(1));
        chk("fault_no_req",  64'(imem_req_valid), 64'(0));
        chk("fault_no_inst", 64'(inst_valid),     64'(0));
        do_reset();
        #1 chk("fault_cleared", 64'(fault),         64'(0));
        chk("fault_rst_pc",  64'(imem_req_addr), 64'(RESET_PC));

        // request held while memory is not ready
        inst_ready = 1'b1;
        @(negedge clk);
        #1 chk("hold_first", 64'(imem_req_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("hold_valid", 64'(imem_req_valid), 64'(1));
            chk("hold_addr", 64'(imem_req_addr), 64'(RESET_PC));
        end
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1 chk("after_accept_addr", 64'(imem_req_addr), 64'(RESET_PC + 32'h4));

        // randomized traffic with aligned redirects
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            rnd = $urandom;
            case ($urandom_range(0, 2))
                0:       redirect_pc = {20'h0, rnd[11:2], 2'b00};
                1:       redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = {rnd[31:2], 2'b00};
            endcase
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
